// File: rtl/button_event_encoder.sv
// Turns five raw bouncing buttons into priority-serialised single-cycle event pulses.
// Each button is synchronised, debounced and rise-detected before it reaches the issue stage.
module button_event_encoder #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_large,
    input  logic btn_seven,
    input  logic btn_small,
    input  logic btn_deck,
    input  logic btn_back,
    output logic large_add,
    output logic seven_add,
    output logic small_add,
    output logic deck_add,
    output logic back,
    output logic dropped
);

    // Bit order is issue priority, highest first: deck, back, large, seven, small.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0]       raw;
    logic [4:0]       sync1;
    logic [4:0]       sync2;
    logic [4:0]       stable;
    logic [4:0]       pending;
    logic [4:0]       events;
    logic [CNT_W-1:0] cnt [5];

    logic [4:0] accept;
    logic [4:0] rise;
    logic [4:0] grant;
    logic [4:0] pending_next;
    logic       drop_any;

    assign raw = {btn_small, btn_seven, btn_large, btn_back, btn_deck};

    always_comb begin
        accept = '0;
        for (int unsigned i = 0; i < 5; i++) begin
            accept[i] = (sync2[i] != stable[i]) && (cnt[i] == LAST);
        end
        rise         = accept & sync2;
        grant        = pending & (~pending + 5'd1);
        // A fresh rise on the button being issued re-arms it rather than counting as a drop.
        pending_next = (pending & ~grant) | rise;
        drop_any     = |(rise & pending & ~grant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            stable  <= '0;
            pending <= '0;
            events  <= '0;
            dropped <= 1'b0;
            for (int unsigned i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            pending <= pending_next;
            events  <= grant;
            dropped <= drop_any;
            for (int unsigned i = 0; i < 5; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (accept[i]) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else if (cnt[i] != '1) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign deck_add  = events[0];
    assign back      = events[1];
    assign large_add = events[2];
    assign seven_add = events[3];
    assign small_add = events[4];

endmodule

// File: tb/tb_button_event_encoder.sv
// Randomised and scenario-driven bench for button_event_encoder against a sliding-window reference model.
module tb_button_event_encoder;

    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] b = '0;  // port order: large, seven, small, deck, back
    logic large_add, seven_add, small_add, deck_add, back, dropped;

    int checks = 0;
    int errors = 0;

    button_event_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .btn_large(b[0]), .btn_seven(b[1]), .btn_small(b[2]),
        .btn_deck(b[3]), .btn_back(b[4]),
        .large_add(large_add), .seven_add(seven_add), .small_add(small_add),
        .deck_add(deck_add), .back(back), .dropped(dropped)
    );

    always #5 clk = ~clk;

    // h[i][k] holds the raw sample taken k+1 edges ago.
    bit         h [5][D+1];
    bit         ms [5];
    bit         mp [5];
    logic [5:0] exp_o;
    int         prio [5] = '{3, 4, 0, 1, 2};

    function automatic logic [5:0] observed();
        return {dropped, back, deck_add, small_add, seven_add, large_add};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, want);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) begin
            ms[i] = 1'b0;
            mp[i] = 1'b0;
            for (int k = 0; k <= D; k++) h[i][k] = 1'b0;
        end
        exp_o = '0;
    endfunction

    function automatic void model_edge(input logic [4:0] r);
        bit rise [5];
        bit flip;
        int g = -1;
        logic [5:0] o = '0;
        for (int i = 0; i < 5; i++) begin
            // The accepted level flips once the D synchronised samples seen so far all disagree with it.
            flip = 1'b1;
            for (int k = 1; k <= D; k++) if (h[i][k] == ms[i]) flip = 1'b0;
            rise[i] = 1'b0;
            if (flip) begin
                ms[i]   = !ms[i];
                rise[i] = ms[i];
            end
        end
        for (int p = 0; p < 5; p++) if (g < 0 && mp[prio[p]]) g = prio[p];
        for (int i = 0; i < 5; i++) if (rise[i] && mp[i] && i != g) o[5] = 1'b1;
        if (g >= 0) begin
            mp[g] = 1'b0;
            o[g]  = 1'b1;
        end
        for (int i = 0; i < 5; i++) begin
            if (rise[i]) mp[i] = 1'b1;
            for (int k = D; k >= 1; k--) h[i][k] = h[i][k-1];
            h[i][0] = r[i];
        end
        exp_o = o;
    endfunction

    task automatic step(input logic [4:0] r);
        b = r;
        @(posedge clk);
        if (rst) model_reset();
        else model_edge(r);
        #1;
        chk("events", 32'(observed()), 32'(exp_o));
        chk("onehot", 32'($countones(observed() & 6'h1f) <= 1), 32'd1);
    endtask

    task automatic hold(input logic [4:0] r, input int n);
        for (int i = 0; i < n; i++) step(r);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_async", 32'(observed()), 32'd0);
        step(b);
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        chk("rst_init", 32'(observed()), 32'd0);
        hold('0, 2);
        rst = 1'b0;
        hold('0, 3);

        hold(5'b00001, 20);                  // single press of large
        hold('0, 12);

        step(5'b00100); step('0); step(5'b00100); step('0);
        hold(5'b00100, 15);                  // bounce then hold on small
        hold('0, 10);

        hold(5'b01101, 15);                  // small, large, deck together
        hold('0, 10);

        hold(5'b11000, 12);                  // back plus deck traffic, release back, re-press
        hold(5'b01000, 2);
        hold(5'b11000, 12);
        hold('0, 10);

        hold(5'b00010, 3);                   // seven pressed, reset mid-debounce while held
        pulse_reset();
        hold(5'b00010, 12);
        hold('0, 10);

        hold(5'b01000, 3);                   // short deck glitch
        hold('0, 12);

        for (int n = 0; n < 4000; n++) begin
            logic [4:0] r;
            r = b;
            for (int i = 0; i < 5; i++) if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
            if ($urandom_range(0, 699) == 0) pulse_reset();
            else step(r);
        end
        hold('0, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
